uart_tx_buf: RTL and testbench
==============================

Name: uart_tx_buf

Overview:
- Buffered UART transmitter, 8N1, LSB first; serial counterpart of the existing UART receive path.
- Accepts bytes over a valid/ready write port into a small FIFO and serializes them back-to-back on `tx`.
- Sits between core logic (result streaming) and the board TX pin.
- Decouples bursty producers from the 115200-baud line.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz
- BAUD, 115200, line rate; bit period DIV = CLK_HZ/BAUD (integer division), 868 at defaults
- DEPTH, 16, FIFO depth in bytes; power of two, >= 2

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- wr_vld  in  1  write strobe; byte accepted on a rising edge where wr_vld & wr_rdy
- wr_data  in  8  byte to transmit
- wr_rdy  out  1  FIFO not full
- tx  out  1  serial line, idle high
- tx_busy  out  1  high while the FIFO is non-empty or a frame is in progress
- level  out  $clog2(DEPTH)+1  bytes currently held in the FIFO (excludes the byte being shifted)

Behaviour:
- Reset values: tx=1, tx_busy=0, wr_rdy=1, level=0.
  - FIFO pointers cleared, FSM=IDLE, baud counter=0, bit index=0.
- Reset asserted mid-frame: tx returns to 1 at the next edge; the partial frame and all buffered bytes are discarded.
- Write port:
  - Accept when wr_vld & wr_rdy; wr_rdy = (level != DEPTH).
  - Writes while full are dropped with no error flag; the producer must honour wr_rdy.
  - A write and a pop in the same cycle leave level unchanged.
  - A write while full is rejected even if a pop occurs in the same cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop head into shift register, go to START, clear baud counter; else hold tx=1.
  - START: tx=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for DIV cycles, then shift right. After bit index 7, go to STOP.
  - STOP: tx=1 for DIV cycles. At the end, if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Baud counter: counts 0..DIV-1 and wraps; a state/bit advance occurs on the wrap cycle.
- Frame length: exactly 10*DIV clocks; consecutive frames are contiguous.
- Latency: with FSM idle and FIFO empty, a byte accepted at edge N drives tx low from edge N+2 (one edge for the FIFO write, one for the pop/load).
- tx is a registered output; no combinational path from inputs to tx.
- tx_busy = (FSM != IDLE) | (level != 0), registered.
  - Falls on the edge where STOP completes with the FIFO empty.
- FIFO pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are derived from level.

Decomposition:
- Package uart_pkg:
  - CLK_HZ and BAUD defaults, DIV computation function.
  - tx_state_t enum {IDLE, START, DATA, STOP}.
  - Shared with the receiver.
- Sub-module uart_byte_fifo: synchronous FIFO, parameter DEPTH.
  - Ports: clk, reset, push, din[7:0], pop, dout[7:0], level.
  - dout shows the head combinationally (first-word fall-through).
  - Contains no pop-when-empty guard; the FSM pops only when non-empty.

Test Plan:
1. Single byte, defaults: write 0x00 at edge N.
   - tx falls at N+2 and stays low 9*868 = 7812 clocks, then high 868 clocks.
   - tx_busy falls at N+2+8680.
2. Bit order: write 0x31.
   - Sampling tx at mid-bit gives start 0, data 1,0,0,0,1,1,0,0, stop 1.
   - Each bit is exactly 868 clocks.
3. Back-to-back: write 0xFF, 0x01, 0x80 on consecutive cycles.
   - Three contiguous frames, 26040 clocks total, no idle gap between stop and start.
   - level peaks at 2; tx_busy stays high throughout.
4. Overflow: from idle, assert wr_vld for 20 consecutive cycles with data 0..19.
   - Bytes 0..16 accepted; wr_rdy low from the cycle after byte 16; level=16.
   - Bytes 17..19 dropped; exactly 17 frames transmitted, carrying 0..16 in order.
5. Loopback: tie tx to the existing uart rx and send 0x00, 0xFF, 0x01, 0x80, 0x31, 0x00.
   - rx_vld pulses six times with rx_data matching, in order.
6. Reset mid-frame: write 0xA5 and 0x5A, then assert reset for one cycle 3000 clocks into the first frame.
   - tx=1 and tx_busy=0 from the next edge.
   - No further frames are sent; level=0, wr_rdy=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default line settings, bit-period helper and the
// transmit FSM state type (also used by the receive path).
package uart_pkg;

    localparam int unsigned CLK_HZ_DEFAULT = 32'd100_000_000;
    localparam int unsigned BAUD_DEFAULT   = 32'd115_200;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with first-word fall-through read; the caller must not pop when
// empty or push when full.
module uart_byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;

    // Storage array write port
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally; occupancy tracks push/pop balance
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            level_r <= level_r + LW'(push) - LW'(pop);
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign level = level_r;

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: bytes enter a FIFO over valid/ready and are
// shifted out LSB first with contiguous frames while data remains.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT,
    parameter int unsigned BAUD   = BAUD_DEFAULT,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_vld,
    input  logic [7:0]               wr_data,
    output logic                     wr_rdy,
    output logic                     tx,
    output logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);
    localparam int unsigned CW  = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
    localparam int unsigned LW  = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 32'd1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    tx_state_t     state_r;
    tx_state_t     state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          tx_r;
    logic          tx_busy_r;
    logic          wr_rdy_r;
    logic          tx_nxt_s;
    logic          push_s;
    logic          pop_s;
    logic          wrap_s;
    logic          nonempty_s;
    logic [7:0]    fifo_dout_s;
    logic [LW-1:0] fifo_level_s;
    logic [LW-1:0] level_nxt_s;

    assign push_s      = wr_vld & wr_rdy_r;
    assign wrap_s      = (cnt_r == CNT_LAST);
    assign nonempty_s  = (fifo_level_s != {LW{1'b0}});
    assign level_nxt_s = fifo_level_s + LW'(push_s) - LW'(pop_s);

    uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .din   (wr_data),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .level (fifo_level_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; every phase lasts one full baud period
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (nonempty_s) state_nxt_s = START;
                else            state_nxt_s = IDLE;
            end
            START: begin
                if (wrap_s) state_nxt_s = DATA;
                else        state_nxt_s = START;
            end
            DATA: begin
                if (wrap_s && (bit_idx_r == 3'd7)) state_nxt_s = STOP;
                else                               state_nxt_s = DATA;
            end
            STOP: begin
                if (wrap_s) state_nxt_s = nonempty_s ? START : IDLE;
                else        state_nxt_s = STOP;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: FIFO pop strobe and next line level
    always_comb begin
        pop_s    = 1'b0;
        tx_nxt_s = 1'b1;
        case (state_r)
            IDLE: begin
                pop_s    = nonempty_s;
                tx_nxt_s = 1'b1;
            end
            START: begin
                pop_s    = 1'b0;
                tx_nxt_s = 1'b0;
            end
            DATA: begin
                pop_s    = 1'b0;
                tx_nxt_s = shift_r[0];
            end
            STOP: begin
                pop_s    = wrap_s & nonempty_s;
                tx_nxt_s = 1'b1;
            end
            default: begin
                pop_s    = 1'b0;
                tx_nxt_s = 1'b1;
            end
        endcase
    end

    // Baud counter, bit index and shift register; a pop reloads the frame
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r     <= {CW{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
        end else if (pop_s) begin
            cnt_r     <= {CW{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= fifo_dout_s;
        end else if (state_r == IDLE) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= wrap_s ? {CW{1'b0}} : (cnt_r + CW'(1));
            if (wrap_s && (state_r == DATA)) begin
                shift_r   <= {1'b0, shift_r[7:1]};
                bit_idx_r <= bit_idx_r + 3'd1;
            end
        end
    end

    // Registered port outputs; ready looks one write ahead so it never overfills
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_r      <= 1'b1;
            tx_busy_r <= 1'b0;
            wr_rdy_r  <= 1'b1;
        end else begin
            tx_r      <= tx_nxt_s;
            tx_busy_r <= (state_r != IDLE) | nonempty_s;
            wr_rdy_r  <= (level_nxt_s != FULL_LEVEL);
        end
    end

    assign tx      = tx_r;
    assign tx_busy = tx_busy_r;
    assign wr_rdy  = wr_rdy_r;
    assign level   = fifo_level_s;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf at a short bit period: a serial monitor
// decodes frames from tx and a byte scoreboard checks them in order.
module tb_uart_tx_buf;

    localparam int DIV   = 16;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_vld = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_rdy;
    logic       tx;
    logic       tx_busy;
    logic [4:0] level;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int fe_cnt = 0;
    bit mon_en = 1'b1;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int starts_q[$];

    uart_tx_buf #(.CLK_HZ(160), .BAUD(10), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_vld  (wr_vld),
        .wr_data (wr_data),
        .wr_rdy  (wr_rdy),
        .tx      (tx),
        .tx_busy (tx_busy),
        .level   (level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Serial monitor: mid-bit sampling of each 8N1 frame seen on tx
    initial begin : rx_mon
        logic [7:0] b;
        b = 8'h00;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                starts_q.push_back(cyc);
                repeat (DIV / 2) @(negedge clk);
                if (tx !== 1'b0 && mon_en) fe_cnt++;
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = tx;
                end
                repeat (DIV) @(negedge clk);
                if (tx !== 1'b1 && mon_en) fe_cnt++;
                if (mon_en) rx_q.push_back(b);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b, input bit accept);
        wr_vld  = 1'b1;
        wr_data = b;
        if (accept) exp_q.push_back(b);
        step(1);
        wr_vld  = 1'b0;
    endtask

    task automatic check_rx(input string tag);
        int t;
        logic [7:0] got;
        logic [7:0] e;
        t = 0;
        while (rx_q.size() == 0 && t < 20 * DIV) begin
            step(1);
            t++;
        end
        if (rx_q.size() == 0) begin
            chk({tag, "_timeout"}, 32'(rx_q.size()), 32'd1);
        end else begin
            got = rx_q.pop_front();
            e   = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            chk(tag, 32'(got), 32'(e));
        end
    endtask

    initial begin
        int s0;
        int busy_low;
        int mlevel;
        bit acc;

        // Reset state
        step(3);
        reset = 1'b0;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_rdy", 32'(wr_rdy), 32'd1);
        chk("rst_level", 32'(level), 32'd0);
        step(2);

        // 1: single 0x00, exact latency and frame length
        wr(8'h00, 1'b1);
        chk("t1_level", 32'(level), 32'd1);
        step(1);
        chk("t1_tx_n1", 32'(tx), 32'd1);
        chk("t1_busy_n1", 32'(tx_busy), 32'd1);
        step(1);
        chk("t1_tx_n2", 32'(tx), 32'd0);
        step(9 * DIV - 1);
        chk("t1_tx_lowend", 32'(tx), 32'd0);
        step(1);
        chk("t1_tx_stop", 32'(tx), 32'd1);
        step(DIV - 1);
        chk("t1_busy_last", 32'(tx_busy), 32'd1);
        step(1);
        chk("t1_busy_fall", 32'(tx_busy), 32'd0);
        check_rx("t1_rx");
        step(DIV);

        // 2: bit order
        wr(8'h31, 1'b1);
        check_rx("t2_rx");
        step(2 * DIV);

        // 3: back-to-back frames
        s0 = starts_q.size();
        wr_vld = 1'b1;
        wr_data = 8'hFF; exp_q.push_back(8'hFF); step(1);
        chk("t3_level_a", 32'(level), 32'd1);
        wr_data = 8'h01; exp_q.push_back(8'h01); step(1);
        chk("t3_level_b", 32'(level), 32'd1);
        wr_data = 8'h80; exp_q.push_back(8'h80); step(1);
        wr_vld = 1'b0;
        chk("t3_level_peak", 32'(level), 32'd2);
        busy_low = 0;
        for (int i = 0; i < 30 * DIV - 1; i++) begin
            step(1);
            if (tx_busy !== 1'b1) busy_low++;
        end
        chk("t3_busy_gaps", 32'(busy_low), 32'd0);
        step(1);
        chk("t3_busy_end", 32'(tx_busy), 32'd0);
        check_rx("t3_rx0");
        check_rx("t3_rx1");
        check_rx("t3_rx2");
        chk("t3_frames", 32'(starts_q.size() - s0), 32'd3);
        if (starts_q.size() >= s0 + 3) begin
            chk("t3_gap0", 32'(starts_q[s0 + 1] - starts_q[s0]), 32'(10 * DIV));
            chk("t3_gap1", 32'(starts_q[s0 + 2] - starts_q[s0 + 1]), 32'(10 * DIV));
        end
        step(2 * DIV);

        // 4: overflow from idle, 20 consecutive writes
        mlevel = 0;
        s0 = starts_q.size();
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("t4_rdy%0d", k), 32'(wr_rdy), 32'(mlevel != DEPTH));
            acc = (mlevel != DEPTH);
            wr_vld  = 1'b1;
            wr_data = 8'(k);
            if (acc) exp_q.push_back(8'(k));
            step(1);
            mlevel = mlevel + int'(acc) - ((k == 1) ? 1 : 0);
        end
        wr_vld = 1'b0;
        chk("t4_level", 32'(level), 32'd16);
        chk("t4_rdy_full", 32'(wr_rdy), 32'd0);
        for (int k = 0; k < 17; k++) check_rx($sformatf("t4_rx%0d", k));
        step(3 * 10 * DIV);
        chk("t4_frames", 32'(starts_q.size() - s0), 32'd17);
        chk("t4_extra_rx", 32'(rx_q.size()), 32'd0);

        // 5: loopback sequence
        wr_vld = 1'b1;
        wr_data = 8'h00; exp_q.push_back(8'h00); step(1);
        wr_data = 8'hFF; exp_q.push_back(8'hFF); step(1);
        wr_data = 8'h01; exp_q.push_back(8'h01); step(1);
        wr_data = 8'h80; exp_q.push_back(8'h80); step(1);
        wr_data = 8'h31; exp_q.push_back(8'h31); step(1);
        wr_data = 8'h00; exp_q.push_back(8'h00); step(1);
        wr_vld = 1'b0;
        for (int k = 0; k < 6; k++) check_rx($sformatf("t5_rx%0d", k));
        chk("t5_framing", 32'(fe_cnt), 32'd0);
        step(2 * DIV);

        // 6: reset in the middle of the first frame
        wr(8'hA5, 1'b0);
        wr(8'h5A, 1'b0);
        step(5 * DIV - 3);
        mon_en = 1'b0;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t6_tx", 32'(tx), 32'd1);
        chk("t6_busy", 32'(tx_busy), 32'd0);
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_rdy", 32'(wr_rdy), 32'd1);
        s0 = starts_q.size();
        step(4 * 10 * DIV);
        chk("t6_no_frames", 32'(starts_q.size() - s0), 32'd0);
        chk("t6_tx_idle", 32'(tx), 32'd1);
        chk("t6_busy_idle", 32'(tx_busy), 32'd0);
        chk("t6_exp_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
